// File: rtl/duc_pkg.sv
// Shared state encoding and DUC-facing constants for the frame arbiter.
package duc_pkg;
    typedef enum logic [2:0] {IDLE, ARB, XFER, DRAIN, GAP} arb_state_t;
    localparam int DUC_TABLE_LEN = 680;
    localparam int DUC_DW        = 8;
endpackage

// File: rtl/duc_axis_reg.sv
// Single-stage AXI-stream register; data holds while valid and not ready.
module duc_axis_reg #(
    parameter int W = 17
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    input  logic [W-1:0] i_s_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [W-1:0] o_m_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_s_ready = !r_valid || i_m_ready;
    assign o_m_valid = r_valid;
    assign o_m_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_s_valid && o_s_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_s_data;
        end else if (i_m_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/duc_frame_arb.sv
// Frame-granular arbiter between payload (src 0) and pilot (src 1) I/Q streams,
// with truncation at the carrier-table length and a forced inter-frame gap.
module duc_frame_arb #(
    parameter int MAX_LEN = duc_pkg::DUC_TABLE_LEN,
    parameter int GAP     = 4,
    parameter int DW      = duc_pkg::DUC_DW
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          enable,
    input  logic          prio_mode,
    input  logic          s0_tvalid,
    output logic          s0_tready,
    input  logic [DW-1:0] s0_tdata_i,
    input  logic [DW-1:0] s0_tdata_q,
    input  logic          s0_tlast,
    input  logic          s1_tvalid,
    output logic          s1_tready,
    input  logic [DW-1:0] s1_tdata_i,
    input  logic [DW-1:0] s1_tdata_q,
    input  logic          s1_tlast,
    output logic          m_tvalid_i,
    output logic          m_tvalid_q,
    input  logic          m_tready_i,
    input  logic          m_tready_q,
    output logic [DW-1:0] m_tdata_i,
    output logic [DW-1:0] m_tdata_q,
    output logic          m_tlast_i,
    output logic          m_tlast_q,
    output logic [1:0]    grant,
    output logic [15:0]   frame_cnt0,
    output logic [15:0]   frame_cnt1,
    output logic          overlen_err
);
    import duc_pkg::*;

    localparam int BW = $clog2(MAX_LEN + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    arb_state_t     r_state, w_next;
    logic [1:0]     r_grant;
    logic           r_pick, r_last_src, r_overlen;
    logic [BW-1:0]  r_beat_cnt;
    logic [GW-1:0]  r_gap_cnt;
    logic [15:0]    r_frame_cnt0, r_frame_cnt1;

    logic           w_m_rdy, w_reg_rdy, w_reg_vld;
    logic           w_src_vld, w_src_last, w_acc, w_drop;
    logic           w_beat_max, w_frm_done, w_trunc, w_gap_done, w_pick;
    logic [DW-1:0]  w_src_i, w_src_q;
    logic [2*DW:0]  w_reg_din, w_reg_dout;

    assign w_m_rdy    = m_tready_i & m_tready_q;
    assign w_src_vld  = r_grant[1] ? s1_tvalid  : s0_tvalid;
    assign w_src_last = r_grant[1] ? s1_tlast   : s0_tlast;
    assign w_src_i    = r_grant[1] ? s1_tdata_i : s0_tdata_i;
    assign w_src_q    = r_grant[1] ? s1_tdata_q : s0_tdata_q;
    assign w_beat_max = (r_beat_cnt == BW'(MAX_LEN - 1));
    assign w_frm_done = (w_acc | w_drop) & w_src_last;
    assign w_trunc    = w_acc & w_beat_max & ~w_src_last;
    assign w_gap_done = (int'(r_gap_cnt) >= GAP - 1);

    // Round-robin ties go to whichever source was not served last.
    always_comb begin
        if (prio_mode)
            w_pick = s1_tvalid;
        else if (s0_tvalid && s1_tvalid)
            w_pick = ~r_last_src;
        else
            w_pick = s1_tvalid;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (enable && (s0_tvalid || s1_tvalid)) w_next = ARB;
            ARB:         w_next = XFER;
            XFER, DRAIN: begin
                if (w_frm_done)   w_next = (GAP == 0) ? IDLE : duc_pkg::GAP;
                else if (w_trunc) w_next = DRAIN;
            end
            duc_pkg::GAP: if (w_gap_done) w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    always_comb begin
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        w_acc     = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            XFER: begin
                s0_tready = r_grant[0] & w_reg_rdy;
                s1_tready = r_grant[1] & w_reg_rdy;
                w_acc     = w_src_vld & w_reg_rdy;
            end
            DRAIN: begin
                s0_tready = r_grant[0];
                s1_tready = r_grant[1];
                w_drop    = w_src_vld;
            end
            default: ;
        endcase
    end

    // The pick is latched every IDLE cycle so a source dropping valid in ARB keeps its grant.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant      <= '0;
            r_pick       <= 1'b0;
            r_last_src   <= 1'b1;
            r_overlen    <= 1'b0;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
        end else begin
            r_overlen <= w_trunc;
            r_gap_cnt <= (r_state == duc_pkg::GAP) ? r_gap_cnt + 1'b1 : '0;
            if (r_state == IDLE) r_pick <= w_pick;
            if (r_state == ARB) begin
                r_grant    <= r_pick ? 2'b10 : 2'b01;
                r_beat_cnt <= '0;
            end
            if (w_acc) r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_frm_done) begin
                r_grant    <= '0;
                r_last_src <= r_grant[1];
                if (r_grant[1]) r_frame_cnt1 <= r_frame_cnt1 + 1'b1;
                else            r_frame_cnt0 <= r_frame_cnt0 + 1'b1;
            end
        end
    end

    assign w_reg_din = {w_src_i, w_src_q, w_src_last | w_beat_max};

    duc_axis_reg #(.W(2*DW+1)) u_oreg (
        .i_clk     (aclk),
        .i_rst_n   (aresetn),
        .i_s_valid (w_acc),
        .o_s_ready (w_reg_rdy),
        .i_s_data  (w_reg_din),
        .o_m_valid (w_reg_vld),
        .i_m_ready (w_m_rdy),
        .o_m_data  (w_reg_dout)
    );

    assign m_tvalid_i  = w_reg_vld;
    assign m_tvalid_q  = w_reg_vld;
    assign m_tdata_i   = w_reg_dout[2*DW:DW+1];
    assign m_tdata_q   = w_reg_dout[DW:1];
    assign m_tlast_i   = w_reg_dout[0];
    assign m_tlast_q   = w_reg_dout[0];
    assign grant       = r_grant;
    assign frame_cnt0  = r_frame_cnt0;
    assign frame_cnt1  = r_frame_cnt1;
    assign overlen_err = r_overlen;
endmodule

// File: tb/tb_duc_frame_arb.sv
// Directed bench for duc_frame_arb: source models, output monitor, checked steps.
module tb_duc_frame_arb;
    logic       aclk, aresetn, enable, prio_mode;
    logic       s0_tvalid, s0_tready, s0_tlast, s1_tvalid, s1_tready, s1_tlast;
    logic [7:0] s0_tdata_i, s0_tdata_q, s1_tdata_i, s1_tdata_q;
    logic       m_tvalid_i, m_tvalid_q, m_tready_i, m_tready_q, m_tlast_i, m_tlast_q;
    logic [7:0] m_tdata_i, m_tdata_q;
    logic [1:0] grant;
    logic [15:0] frame_cnt0, frame_cnt1;
    logic       overlen_err;

    int n_checks, n_errors, cyc;
    int req [2], len [2], done [2], beat [2], seq [2];
    logic tv [2], tl [2];
    logic [7:0] ti [2], tq [2];
    int st_src [$], st_cyc [$], end_cyc [$];
    logic [7:0] oq_i [$], oq_q [$];
    logic oq_l [$];
    int ovl_cnt, skew_cnt;

    duc_frame_arb #(.MAX_LEN(680), .GAP(4), .DW(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .prio_mode(prio_mode),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata_i(s0_tdata_i),
        .s0_tdata_q(s0_tdata_q), .s0_tlast(s0_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata_i(s1_tdata_i),
        .s1_tdata_q(s1_tdata_q), .s1_tlast(s1_tlast),
        .m_tvalid_i(m_tvalid_i), .m_tvalid_q(m_tvalid_q),
        .m_tready_i(m_tready_i), .m_tready_q(m_tready_q),
        .m_tdata_i(m_tdata_i), .m_tdata_q(m_tdata_q),
        .m_tlast_i(m_tlast_i), .m_tlast_q(m_tlast_q),
        .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1),
        .overlen_err(overlen_err)
    );

    assign s0_tvalid = tv[0]; assign s0_tlast = tl[0];
    assign s0_tdata_i = ti[0]; assign s0_tdata_q = tq[0];
    assign s1_tvalid = tv[1]; assign s1_tlast = tl[1];
    assign s1_tdata_i = ti[1]; assign s1_tdata_q = tq[1];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    initial cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Source model: frames of len[s] beats, req[s] frames requested in total.
    initial begin : src_model
        bit h [2];
        int hc;
        for (int s = 0; s < 2; s++) begin
            tv[s] = 1'b0; tl[s] = 1'b0; ti[s] = '0; tq[s] = '0;
            done[s] = 0; beat[s] = 0; seq[s] = 0;
        end
        forever begin
            @(negedge aclk);
            h[0] = s0_tvalid && s0_tready;
            h[1] = s1_tvalid && s1_tready;
            hc = cyc;
            @(posedge aclk); #2;
            for (int s = 0; s < 2; s++) begin
                if (!aresetn) begin
                    beat[s] = 0; seq[s] = 0; done[s] = req[s];
                end else if (h[s]) begin
                    if (beat[s] == 0) begin st_src.push_back(s); st_cyc.push_back(hc); end
                    seq[s]++; beat[s]++;
                    if (beat[s] == len[s]) begin
                        beat[s] = 0; done[s]++; end_cyc.push_back(hc);
                    end
                end
                tv[s] = aresetn && (done[s] < req[s]);
                ti[s] = 8'((s << 7) | (seq[s] & 127));
                tq[s] = ti[s] ^ 8'h5A;
                tl[s] = (beat[s] == len[s] - 1);
            end
        end
    end

    initial begin : monitor
        ovl_cnt = 0; skew_cnt = 0;
        forever begin
            @(negedge aclk);
            if (m_tvalid_i && m_tready_i && m_tready_q) begin
                oq_i.push_back(m_tdata_i); oq_q.push_back(m_tdata_q); oq_l.push_back(m_tlast_i);
            end
            if (overlen_err) ovl_cnt++;
            if (m_tvalid_i !== m_tvalid_q || m_tlast_i !== m_tlast_q) skew_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge aclk); #1;
    endtask

    task automatic do_reset();
        sync(); aresetn = 1'b0;
        sync(); aresetn = 1'b1;
        sync(); sync();
    endtask

    task automatic wait_fc(input int s, input int n, input int lim, input string tag);
        int k = 0;
        while (((s == 0) ? int'(frame_cnt0) : int'(frame_cnt1)) < n && k < lim) begin
            @(negedge aclk); k++;
        end
        chk(tag, 32'(k < lim), 1);
        sync(); sync(); sync();
    endtask

    task automatic chk_frame(input string tag, input int ob, input int n, input int src, input int seqb);
        int bad = 0;
        chk({tag, "_cnt"}, 32'(oq_i.size() - ob), 32'(n));
        for (int k = 0; k < n; k++) begin
            logic [7:0] ei;
            ei = 8'((src << 7) | ((seqb + k) & 127));
            if (oq_i[ob+k] !== ei || oq_q[ob+k] !== (ei ^ 8'h5A) || oq_l[ob+k] !== (k == n - 1))
                bad++;
        end
        chk({tag, "_data"}, 32'(bad), 0);
    endtask

    initial begin : main
        int ob, sb, eb, ovb, c0, seqb, k, bad;
        n_checks = 0; n_errors = 0;
        aresetn = 1'b0; enable = 1'b0; prio_mode = 1'b0;
        m_tready_i = 1'b1; m_tready_q = 1'b1;
        req[0] = 0; req[1] = 0; len[0] = 1; len[1] = 1;
        repeat (3) @(posedge aclk); #1;
        chk("rst_mvalid", 32'(m_tvalid_i), 0);
        chk("rst_mdata",  32'(m_tdata_i), 0);
        chk("rst_mlast",  32'(m_tlast_i), 0);
        chk("rst_grant",  32'(grant), 0);
        chk("rst_fc0",    32'(frame_cnt0), 0);
        chk("rst_fc1",    32'(frame_cnt1), 0);
        chk("rst_ovl",    32'(overlen_err), 0);
        chk("rst_s0rdy",  32'(s0_tready), 0);
        aresetn = 1'b1; enable = 1'b1;
        sync(); sync();

        // 10-beat payload frame
        do_reset();
        ob = oq_i.size(); sb = st_cyc.size();
        len[0] = 10; c0 = cyc; req[0] = req[0] + 1;
        wait_fc(0, 1, 200, "t1_done");
        chk("t1_latency", 32'(st_cyc[sb] - c0), 2);
        chk_frame("t1", ob, 10, 0, 0);
        chk("t1_fc0", 32'(frame_cnt0), 1);
        chk("t1_fc1", 32'(frame_cnt1), 0);

        // round robin with both sources always valid
        do_reset();
        sb = st_cyc.size(); eb = end_cyc.size();
        len[0] = 3; len[1] = 3;
        req[0] = req[0] + 2; req[1] = req[1] + 2;
        wait_fc(1, 2, 300, "t2_done");
        for (int j = 0; j < 4; j++) chk("t2_order", 32'(st_src[sb+j]), 32'(j % 2));
        for (int j = 0; j < 3; j++) chk("t2_spacing", 32'(st_cyc[sb+j+1] - end_cyc[eb+j] - 1), 6);
        chk("t2_fc0", 32'(frame_cnt0), 2);

        // strict priority for source 1
        do_reset();
        sb = st_cyc.size();
        prio_mode = 1'b1; len[0] = 4; len[1] = 4;
        req[1] = req[1] + 3; req[0] = req[0] + 1;
        wait_fc(0, 1, 300, "t3_done");
        chk("t3_order0", 32'(st_src[sb]), 1);
        chk("t3_order1", 32'(st_src[sb+1]), 1);
        chk("t3_order2", 32'(st_src[sb+2]), 1);
        chk("t3_order3", 32'(st_src[sb+3]), 0);
        chk("t3_fc1", 32'(frame_cnt1), 3);
        prio_mode = 1'b0;

        // 700-beat frame truncated to 680 and drained
        do_reset();
        ob = oq_i.size(); ovb = ovl_cnt;
        len[0] = 700; req[0] = req[0] + 1;
        wait_fc(0, 1, 1500, "t4_done");
        chk_frame("t4", ob, 680, 0, 0);
        chk("t4_ovl", 32'(ovl_cnt - ovb), 1);
        chk("t4_drained", 32'(seq[0]), 700);
        chk("t4_fc0", 32'(frame_cnt0), 1);

        // exactly 680 beats with tlast: no error
        ob = oq_i.size(); ovb = ovl_cnt; seqb = seq[0];
        len[0] = 680; req[0] = req[0] + 1;
        wait_fc(0, 2, 1500, "t4b_done");
        chk_frame("t4b", ob, 680, 0, seqb);
        chk("t4b_ovl", 32'(ovl_cnt - ovb), 0);

        // single-beat pilot frame
        ob = oq_i.size(); seqb = seq[1];
        len[1] = 1; req[1] = req[1] + 1;
        wait_fc(1, 1, 100, "t4c_done");
        chk_frame("t4c", ob, 1, 1, seqb);

        // DUC Q-ready stall mid-frame
        do_reset();
        ob = oq_i.size();
        len[0] = 20; req[0] = req[0] + 1;
        k = 0;
        while (oq_i.size() - ob < 5 && k < 100) begin @(negedge aclk); k++; end
        chk("t5_start", 32'(k < 100), 1);
        sync(); m_tready_q = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge aclk);
            chk("t5_hold_valid", 32'(m_tvalid_i), 1);
            chk("t5_hold_data", 32'(m_tdata_i), 32'(8'(oq_i.size() - ob)));
            chk("t5_s0_tready", 32'(s0_tready), 0);
        end
        sync(); m_tready_q = 1'b1;
        wait_fc(0, 1, 200, "t5_done");
        chk_frame("t5", ob, 20, 0, 0);

        // reset pulsed mid-frame
        ob = oq_i.size(); seqb = seq[0];
        len[0] = 100; req[0] = req[0] + 1;
        k = 0;
        while (seq[0] - seqb < 50 && k < 300) begin @(negedge aclk); k++; end
        chk("t6_reach50", 32'(k < 300), 1);
        sync(); aresetn = 1'b0; #1;
        chk("t6_mvalid_i", 32'(m_tvalid_i), 0);
        chk("t6_mvalid_q", 32'(m_tvalid_q), 0);
        chk("t6_mdata", 32'(m_tdata_i), 0);
        chk("t6_mlast", 32'(m_tlast_i), 0);
        chk("t6_grant", 32'(grant), 0);
        chk("t6_s0rdy", 32'(s0_tready), 0);
        chk("t6_fc0", 32'(frame_cnt0), 0);
        bad = 0;
        for (int j = ob; j < oq_l.size(); j++) if (oq_l[j] !== 1'b0) bad++;
        chk("t6_no_last", 32'(bad), 0);
        sync(); aresetn = 1'b1; sync(); sync();
        ob = oq_i.size();
        len[0] = 5; req[0] = req[0] + 1;
        wait_fc(0, 1, 100, "t6_done");
        chk_frame("t6", ob, 5, 0, 0);
        chk("t6_fc0_after", 32'(frame_cnt0), 1);
        chk("iq_skew", 32'(skew_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
